mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read instruction/data memory between the fetch stage (IF) and the execute-stage load/store path (EX).
- Grants at most one access per cycle. Tracks in-flight reads and routes read data back to the requester that issued the read.
- Raises per-stage stall signals for the pipeline hazard logic.
- Discards in-flight fetch returns when a taken branch or jump flushes the front end.

Parameters:
- ADDR_W, 14: memory word-address width.
- MEM_LAT, 1: memory read latency in cycles from enable to valid dout (1..4).
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits, before fetch is forced through.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  32  fetch byte address.
- if_flush  in  1  pulse from the EX control path (PCSel); kills fetch reads that are in flight.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held until granted.
- d_we  in  4  byte write enables; 0 means a load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, already byte-lane aligned.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load data.
- mem_en  out  1  memory enable.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  ADDR_W  memory word address.
- mem_din  out  32  memory write data.
- mem_dout  in  32  memory read data.
- stall_if  out  1  if_req & ~if_gnt.
- stall_ex  out  1  d_req & ~d_gnt.

Behaviour:
- Grant logic is combinational from the requests and registered state. There is no handshake latency, so an uncontested request is granted in the same cycle.
- Priority: data wins over fetch, except when starve_cnt == STARVE_MAX. In that case fetch wins for that one cycle.
- starve_cnt is a registered counter of width clog2(STARVE_MAX+1):
  - increments on a cycle with d_gnt & if_req;
  - clears on if_gnt or !if_req;
  - saturates at STARVE_MAX.
- Memory drive when granted:
  - mem_en=1.
  - mem_addr = winner addr[ADDR_W+1:2]; address bits [1:0] are ignored.
  - mem_we = d_we for a data grant, 4'b0 for a fetch grant.
  - mem_din = d_wdata.
- With no grant: mem_en=0 and mem_we=0.
- Tag pipeline: a MEM_LAT-deep shift register of {valid, owner}. Bit 1 is pushed on every read grant (fetch, or data with d_we==0); a write pushes valid=0.
- Read return: at depth MEM_LAT, valid sets if_rvalid or d_rvalid (by owner) for one cycle. mem_dout drives both rdata buses unconditionally; consumers qualify with rvalid.
- Back-to-back reads are legal: one return per cycle, in issue order.
- if_flush:
  - clears valid on every fetch-owned tag in the pipeline, including a fetch granted in the same cycle.
  - data tags are unaffected.
  - if_gnt is still asserted that cycle, so the requester drops its request.
- A write followed by a read to the same address in the next cycle returns the new data; the memory is write-first, and no forwarding is done here.
- Reset (async assert, sync deassert is the system's job): starve_cnt=0 and all tags invalid. All registered outputs are 0: if_rvalid, d_rvalid. With requests low, all combinational outputs are 0. Reads in flight at reset are dropped, with no rvalid afterward.
- Simultaneous d_req and if_req with starve_cnt < STARVE_MAX: d_gnt=1, if_gnt=0, stall_if=1.

Decomposition:
- Shared package/header: owner encoding (OWN_IF=0, OWN_D=1) and the tag-entry width. These sit beside the existing opcode/MemRW localparams used by the control units.
- One natural sub-module: rd_tag_pipe, the parameterised MEM_LAT-deep {valid, owner} shift register with a per-owner kill mask.
- Arbitration and the starve counter stay in the top module.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x10, MEM_LAT=1, mem_dout=0xDEADBEEF.
  - Required: if_gnt=1 and mem_addr=4 in cycle 0; if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 1; stall_if=0.
- Contention:
  - Stimulus: d_req (load, 0x20) and if_req together for 1 cycle.
  - Required: d_gnt=1, stall_if=1; fetch granted next cycle. d_rvalid at cycle 1, if_rvalid at cycle 2.
- Starvation:
  - Stimulus: d_req and if_req held high for 8 cycles, STARVE_MAX=4.
  - Required: grant pattern D,D,D,D,IF,D,D,D; stall_ex=1 only in cycle 4.
- Flush:
  - Stimulus: fetch granted cycle 0, MEM_LAT=2, if_flush=1 in cycle 1.
  - Required: no if_rvalid at cycle 2. A data load granted in cycle 1 still returns d_rvalid at cycle 3.
- Store:
  - Stimulus: d_we=4'b0011, d_addr=0x104, d_wdata=0x0000ABCD.
  - Required: mem_we=4'b0011, mem_addr=0x41, no d_rvalid. A load of 0x104 on the next cycle returns 0x????ABCD.
- Reset mid-read:
  - Stimulus: rst_n low for 1 cycle immediately after a read grant.
  - Required: rvalid never asserts; starve_cnt=0; all outputs 0 while requests are low.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: read-tag owner codes and
// tag layout, kept beside the control-unit memory access constants.
package mem_port_arbiter_pkg;

    localparam logic [3:0] MEMRW_LOAD  = 4'b0000;
    localparam logic [3:0] MEMRW_WORD  = 4'b1111;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// MEM_LAT-deep {valid, owner} shift register that follows reads through the
// memory; a per-owner kill mask invalidates matching tags as they advance.
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_valid,
    input  logic       push_owner,
    input  logic [1:0] kill_mask,
    output rd_tag_t    tag_out
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] owner_reg;
    logic [DEPTH-1:0] owner_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // A read granted in a killing cycle never enters live.
                assign valid_next[gi] = push_valid & ~kill_mask[push_owner];
                assign owner_next[gi] = push_owner;
            end else begin : g_body
                assign valid_next[gi] = valid_reg[gi-1] & ~kill_mask[owner_reg[gi-1]];
                assign owner_next[gi] = owner_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            owner_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            owner_reg <= owner_next;
        end
    end

    assign tag_out.valid = valid_reg[DEPTH-1];
    assign tag_out.owner = owner_reg[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read memory between fetch and the
// load/store path: same-cycle grant, data priority with an anti-starvation bound.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              stall_if,
    output logic              stall_ex
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [STARVE_W-1:0] starve_cnt_next;
    logic                fetch_force;
    logic                rd_push;
    logic                rd_owner;
    logic [1:0]          kill_mask;
    rd_tag_t             ret_tag;
    logic                unused_addr_bits;

    // Once fetch has sat through STARVE_MAX data grants it wins one cycle.
    assign fetch_force = (starve_cnt_reg == STARVE_LIM);
    assign d_gnt       = d_req & ~(if_req & fetch_force);
    assign if_gnt      = if_req & ~d_gnt;
    assign stall_if    = if_req & ~if_gnt;
    assign stall_ex    = d_req & ~d_gnt;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (if_gnt || !if_req) begin
            starve_cnt_next = '0;
        end else if (d_gnt && (starve_cnt_reg != STARVE_LIM)) begin
            starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        mem_en   = if_gnt | d_gnt;
        mem_we   = MEMRW_LOAD;
        mem_addr = '0;
        mem_din  = '0;
        if (d_gnt) begin
            mem_we   = d_we;
            mem_addr = d_addr[ADDR_W+1:2];
            mem_din  = d_wdata;
        end else if (if_gnt) begin
            mem_addr = if_addr[ADDR_W+1:2];
            mem_din  = d_wdata;
        end
    end

    // Stores push an invalid tag so the pipe keeps one slot per access cycle.
    assign rd_push   = if_gnt | (d_gnt & (d_we == MEMRW_LOAD));
    assign rd_owner  = d_gnt ? OWN_D : OWN_IF;
    assign kill_mask = {1'b0, if_flush};

    rd_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (rd_push),
        .push_owner (rd_owner),
        .kill_mask  (kill_mask),
        .tag_out    (ret_tag)
    );

    assign if_rvalid = ret_tag.valid & (ret_tag.owner == OWN_IF);
    assign d_rvalid  = ret_tag.valid & (ret_tag.owner == OWN_D);
    assign if_rdata  = mem_dout;
    assign d_rdata   = mem_dout;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a behavioural
// model: predicted grants, a shadow memory and a queue of expected returns.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int LAT    = 2;
    localparam int SMAX   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = '0;
    logic              if_flush = 1'b0;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req = 1'b0;
    logic [3:0]        d_we = '0;
    logic [31:0]       d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_gnt, d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout = '0;
    logic              stall_if, stall_ex;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .MEM_LAT    (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .if_req (if_req), .if_addr (if_addr), .if_flush (if_flush),
        .if_gnt (if_gnt), .if_rvalid (if_rvalid), .if_rdata (if_rdata),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_din (mem_din), .mem_dout (mem_dout),
        .stall_if (stall_if), .stall_ex (stall_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_fetch;
        logic [31:0] data;
        bit          live;
    } ret_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_wait = 0;
    ret_t        ret_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] env_mem [int];
    logic [31:0] rd_pipe [LAT];

    bit          saw_ig, saw_dg, saw_sif, saw_sex, saw_irv, saw_drv;
    logic [31:0] saw_irdata, saw_drdata, saw_addr;
    logic [3:0]  saw_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] env_read(input int a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    // One clock of checking, model update and memory emulation.
    task automatic cycle();
        bit          exp_dg, exp_ig, exp_irv, exp_drv;
        logic [31:0] exp_data, word, exp_addr;
        ret_t        r;
        int          widx;
        @(negedge clk);
        saw_ig = if_gnt;  saw_dg = d_gnt;  saw_sif = stall_if;  saw_sex = stall_ex;
        saw_irv = if_rvalid;  saw_drv = d_rvalid;
        saw_irdata = if_rdata;  saw_drdata = d_rdata;
        saw_we = mem_we;  saw_addr = 32'(mem_addr);

        // Data has priority unless fetch has already waited through SMAX data grants.
        exp_dg = d_req && !(if_req && (m_wait == SMAX));
        exp_ig = if_req && !exp_dg;
        exp_addr = exp_dg ? 32'(d_addr[ADDR_W+1:2]) : (exp_ig ? 32'(if_addr[ADDR_W+1:2]) : 32'h0);
        check_eq("if_gnt", if_gnt, exp_ig);
        check_eq("d_gnt", d_gnt, exp_dg);
        check_eq("stall_if", stall_if, if_req && !exp_ig);
        check_eq("stall_ex", stall_ex, d_req && !exp_dg);
        check_eq("mem_en", mem_en, exp_dg || exp_ig);
        check_eq("mem_we", mem_we, exp_dg ? d_we : 4'h0);
        check_eq("mem_addr", 32'(mem_addr), exp_addr);
        check_eq("mem_din", mem_din, (exp_dg || exp_ig) ? d_wdata : 32'h0);

        exp_irv = 1'b0;  exp_drv = 1'b0;  exp_data = '0;
        while (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            if (r.live) begin
                if (r.is_fetch) exp_irv = 1'b1; else exp_drv = 1'b1;
                exp_data = r.data;
            end
        end
        check_eq("if_rvalid", if_rvalid, exp_irv);
        check_eq("d_rvalid", d_rvalid, exp_drv);
        if (exp_irv) check_eq("if_rdata", if_rdata, exp_data);
        if (exp_drv) check_eq("d_rdata", d_rdata, exp_data);

        if (exp_dg && d_we != 4'h0)
            ref_mem[int'(exp_addr)] = merge(ref_read(int'(exp_addr)), d_wdata, d_we);
        if (exp_ig || (exp_dg && d_we == 4'h0))
            ret_q.push_back('{due: cyc + LAT, is_fetch: exp_ig,
                              data: ref_read(int'(exp_addr)), live: 1'b1});
        // Everything still queued is in flight, so a flush kills all fetch reads.
        if (if_flush)
            foreach (ret_q[i]) if (ret_q[i].is_fetch) ret_q[i].live = 1'b0;
        if (exp_ig || !if_req) m_wait = 0;
        else if (exp_dg && m_wait < SMAX) m_wait++;

        if (saw_ig || saw_dg)
            $display("[%0d] %s addr=%h we=%b flush=%0d", cyc, saw_dg ? "D " : "IF",
                     mem_addr, mem_we, if_flush);

        // Write-first memory emulation driven only by the DUT's memory pins.
        word = '0;
        if (mem_en) begin
            widx = int'(mem_addr);
            word = merge(env_read(widx), mem_din, mem_we);
            if (mem_we != 4'h0) env_mem[widx] = word;
        end
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = word;
        mem_dout = rd_pipe[LAT-1];
        cyc++;
    endtask

    task automatic do_reset();
        if_req = 1'b0;  d_req = 1'b0;  if_flush = 1'b0;  d_we = 4'h0;  d_wdata = '0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_if_rvalid", if_rvalid, 1'b0);
        check_eq("rst_d_rvalid", d_rvalid, 1'b0);
        check_eq("rst_gnts", {if_gnt, d_gnt, stall_if, stall_ex, mem_en}, 5'b0);
        check_eq("rst_mem_we", mem_we, 4'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_mem_din", mem_din, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_rvalid_hold", {if_rvalid, d_rvalid}, 2'b0);
        rst_n = 1'b1;
        ret_q.delete();
        m_wait = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        return {16'($urandom), 9'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
    endfunction

    initial begin
        do_reset();

        // Fetch only, after preloading 0xDEADBEEF at byte address 0x10
        d_req = 1'b1;  d_we = 4'hF;  d_addr = 32'h10;  d_wdata = 32'hDEADBEEF;
        cycle();
        d_req = 1'b0;  d_we = 4'h0;
        if_req = 1'b1;  if_addr = 32'h10;
        cycle();
        check_eq("fo_gnt", saw_ig, 1'b1);
        check_eq("fo_addr", saw_addr, 32'h4);
        check_eq("fo_stall", saw_sif, 1'b0);
        if_req = 1'b0;
        cycle();
        cycle();
        check_eq("fo_rvalid", saw_irv, 1'b1);
        check_eq("fo_rdata", saw_irdata, 32'hDEADBEEF);

        // Store then load of the same word
        d_req = 1'b1;  d_we = 4'b0011;  d_addr = 32'h104;  d_wdata = 32'h0000ABCD;
        cycle();
        check_eq("st_we", saw_we, 4'b0011);
        check_eq("st_addr", saw_addr, 32'h41);
        d_we = 4'h0;
        cycle();
        d_req = 1'b0;
        cycle();
        check_eq("st_no_rvalid", saw_drv, 1'b0);
        cycle();
        check_eq("ld_rvalid", saw_drv, 1'b1);
        check_eq("ld_low_half", saw_drdata & 32'h0000FFFF, 32'h0000ABCD);

        // Contention: data first, fetch next cycle
        d_req = 1'b1;  d_addr = 32'h20;  if_req = 1'b1;  if_addr = 32'h40;
        cycle();
        check_eq("ct_dgnt", saw_dg, 1'b1);
        check_eq("ct_stall_if", saw_sif, 1'b1);
        d_req = 1'b0;
        cycle();
        check_eq("ct_ignt", saw_ig, 1'b1);
        if_req = 1'b0;
        cycle();
        check_eq("ct_drv", saw_drv, 1'b1);
        cycle();
        check_eq("ct_irv", saw_irv, 1'b1);

        // Flush kills the in-flight fetch but not a load issued with it
        if_req = 1'b1;  if_addr = 32'h8;
        cycle();
        if_req = 1'b0;  if_flush = 1'b1;  d_req = 1'b1;  d_addr = 32'h20;
        cycle();
        check_eq("fl_dgnt", saw_dg, 1'b1);
        if_flush = 1'b0;  d_req = 1'b0;
        cycle();
        check_eq("fl_no_irv", saw_irv, 1'b0);
        cycle();
        check_eq("fl_drv", saw_drv, 1'b1);

        // Build up fetch starvation with reads in flight, then reset
        d_req = 1'b1;  d_addr = 32'h30;  if_req = 1'b1;  if_addr = 32'h50;
        for (int k = 0; k < 3; k++) cycle();
        do_reset();

        // Starvation straight out of reset: D,D,D,D,IF,D,D,D
        d_req = 1'b1;  d_addr = 32'h34;  if_req = 1'b1;  if_addr = 32'h54;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_eq("sv_ignt", saw_ig, k == 4);
            check_eq("sv_stall_ex", saw_sex, k == 4);
        end
        if_req = 1'b0;  d_req = 1'b0;
        for (int k = 0; k < LAT + 1; k++) cycle();

        // Randomized traffic with held requests and occasional flushes
        for (int n = 0; n < 400; n++) begin
            if (!if_req || saw_ig) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if (!d_req || saw_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            if_flush = ($urandom_range(0, 7) == 0);
            cycle();
        end
        if_req = 1'b0;  d_req = 1'b0;  if_flush = 1'b0;
        for (int k = 0; k < LAT + 2; k++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
